i4_recon_collector: RTL and testbench
=====================================

# i4_recon_collector

Collects the sixteen reconstructed 4x4 luma sub-blocks of one 16x16 macroblock, in raster i4 order, and extracts the macroblock edges needed as intra-4x4 neighbours by later macroblocks. It sits after the i4 reconstruction stage. It publishes the bottom row (the top line for the macroblock below) and the right column (the left context for the macroblock to the right) through a valid/ready handshake.

## Interface
- No parameters.
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- mb_abort  in  1  synchronous clear of the in-progress macroblock
- blk_valid  in  1  sub-block present
- blk_ready  out  1  collector accepts a sub-block
- blk_idx  in  4  producer's i4 index: bx = blk_idx[1:0], by = blk_idx[3:2]
- blk_data  in  128  reconstructed 4x4 block; pixel (x,y) at [32y+8x +: 8]
- edge_valid  out  1  edge set available
- edge_ready  in  1  consumer takes the edge set
- edge_bottom  out  128  macroblock row 15; pixel x at [8x +: 8]
- edge_right  out  128  macroblock column 15; pixel y at [8y +: 8]
- mb_cnt  out  16  macroblocks delivered, wraps at 65535 -> 0
- idx_err  out  1  sticky; blk_idx differed from the expected index
- mb_pix  out  2048  full macroblock; pixel (x,y) at [128y+8x +: 8]; present only with I4_RECON_FULL_MB_EN

## Operation
- The FSM has two states:
  - COLLECT: blk_ready = 1.
  - FLUSH: blk_ready = 0, edge_valid = 1.
- Acceptance occurs when blk_valid && blk_ready. The internal counter cnt (4 bits) selects the destination; blk_idx does not.
- Edge capture on an accepted block with position bx = cnt[1:0], by = cnt[3:2]:
  - If by == 3: edge_bottom[32bx +: 32] <= blk_data[127:96].
  - If bx == 3: edge_right[32by +: 32] <= {blk_data[127:120], blk_data[95:88], blk_data[63:56], blk_data[31:24]}.
  - Block 15 updates both edges.
- Index check: on acceptance, if blk_idx != cnt then idx_err <= 1. The block is still stored at position cnt. idx_err clears only on reset or mb_abort.
- cnt increments on each acceptance. Accepting block 15 wraps cnt to 0 and moves the FSM to FLUSH.
- FLUSH -> COLLECT on edge_valid && edge_ready. At the same time, mb_cnt increments.
- edge_bottom and edge_right hold their value until they are overwritten by the next macroblock's blocks. They are valid only while edge_valid = 1.
- mb_abort has priority over every other event in the same cycle:
  - cnt <= 0, state <= COLLECT, edge_valid <= 0, idx_err <= 0.
  - Any block offered that cycle is not accepted. blk_ready is still 1 if the state was COLLECT, but acceptance is masked.
  - Edge and pixel storage keep stale data. mb_cnt is unchanged.

## Timing
- Reset values: blk_ready = 1 (COLLECT), edge_valid = 0, edge_bottom = 0, edge_right = 0, mb_cnt = 0, idx_err = 0, mb_pix = 0.
- blk_ready is a decode of the registered state. It does not depend combinationally on blk_valid.
- Back-to-back acceptance at one block per cycle is supported in COLLECT.
- Latency: edge_valid rises on the clock edge that accepts block 15, so it is visible the cycle after that handshake.
- No blocks are accepted while in FLUSH. Minimum macroblock period is 17 cycles with edge_ready tied high.
- edge_valid, once high, stays high with stable data until edge_ready or mb_abort.
- blk_ready returns to 1 in the cycle after the edge handshake. Edge register writes therefore never overlap a pending edge set.
- Reset asserted mid-macroblock discards everything immediately (asynchronous clear).

## Configuration
- I4_RECON_FULL_MB_EN defined:
  - A 2048-bit pixel store and the mb_pix port are compiled in.
  - Each accepted block writes its rows: row r goes to mb_pix[128(4by+r) + 32bx +: 32].
  - mb_pix is valid while edge_valid = 1.
- I4_RECON_FULL_MB_EN undefined: the store and the port are absent. Only the edge registers are built.

## Test plan
- Reset, then send 16 blocks with blk_data = {16{blk_idx*16 + k}} pattern and blk_idx = 0..15 consecutively, with edge_ready = 1.
  - edge_valid pulses the cycle after block 15 for 1 cycle.
  - edge_bottom = rows 3 of blocks 12..15; edge_right = column 3 of blocks 3, 7, 11, 15.
  - mb_cnt = 1.
- Same stimulus with edge_ready = 0 for 5 cycles:
  - edge_valid and the data stay stable and blk_ready = 0 for those cycles.
  - Handshake on cycle 6; blk_ready = 1 the next cycle.
- Send blk_idx = 5 while cnt = 4: idx_err = 1 and the block is stored at position 4. idx_err persists through the edge handshake and clears on mb_abort.
- After 9 blocks, pulse mb_abort together with blk_valid:
  - That block is dropped and cnt = 0.
  - A fresh 16 blocks produce correct edges; mb_cnt advances by 1 only.
- mb_cnt wrap: preload via 65535 completed macroblocks (or force); the next delivery reads 0.
- With I4_RECON_FULL_MB_EN: pixel (x,y) = 16y+x pattern gives mb_pix byte n = n for n = 0..255 while edge_valid = 1.

Source files
------------

// File: rtl/i4_recon_collector.sv
// i4_recon_collector: gathers 16 raster-order i4 sub-blocks of a 16x16 luma MB and extracts bottom row / right column as neighbour context.
// Latency: edge_valid rises on the edge that accepts block 15 (visible next cycle); min MB period 17 cycles.
// Backpressure: blk_ready drops for the whole FLUSH phase until edge_valid && edge_ready; mb_abort overrides all.
// Optional I4_RECON_FULL_MB_EN: adds a full 2048-bit pixel store exported on mb_pix.
module i4_recon_collector (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mb_abort,
    input  logic           blk_valid,
    output logic           blk_ready,
    input  logic [3:0]     blk_idx,
    input  logic [127:0]   blk_data,
    output logic           edge_valid,
    input  logic           edge_ready,
    output logic [127:0]   edge_bottom,
    output logic [127:0]   edge_right,
    output logic [15:0]    mb_cnt,
    output logic           idx_err
`ifdef I4_RECON_FULL_MB_EN
    ,
    output logic [2047:0]  mb_pix
`endif
);

    typedef enum logic {
        COLLECT = 1'b0,
        FLUSH   = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [15:0]    mb_cnt_q, mb_cnt_d;
    logic           idx_err_q, idx_err_d;
    logic [127:0]   bottom_q, bottom_d;
    logic [127:0]   right_q, right_d;
    logic           accept;
    logic           edge_take;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake decode; ready/valid come only from the registered state.
    always_comb begin
        state_d    = state_q;
        blk_ready  = 1'b0;
        edge_valid = 1'b0;
        accept     = 1'b0;
        edge_take  = 1'b0;
        case (state_q)
            COLLECT: begin
                blk_ready = 1'b1;
                accept    = blk_valid && !mb_abort;
                if (accept && (cnt_q == 4'd15)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                edge_valid = 1'b1;
                edge_take  = edge_ready && !mb_abort;
                if (edge_take) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
        // Abort wins over acceptance and edge handshake alike.
        if (mb_abort) begin
            state_d = COLLECT;
        end
    end

    // Datapath next state: position counter, index check, edge capture, MB counter.
    always_comb begin
        cnt_d     = cnt_q;
        mb_cnt_d  = mb_cnt_q;
        idx_err_d = idx_err_q;
        bottom_d  = bottom_q;
        right_d   = right_q;
        if (accept) begin
            cnt_d = cnt_q + 4'd1;
            if (blk_idx != cnt_q) begin
                idx_err_d = 1'b1;
            end
            // Destination comes from cnt, never from the producer's index.
            for (int i = 0; i < 4; i++) begin
                if ((cnt_q[3:2] == 2'd3) && (cnt_q[1:0] == 2'(i))) begin
                    bottom_d[32*i +: 32] = blk_data[127:96];
                end
                if ((cnt_q[1:0] == 2'd3) && (cnt_q[3:2] == 2'(i))) begin
                    right_d[32*i +: 32] = {blk_data[127:120], blk_data[95:88],
                                           blk_data[63:56],   blk_data[31:24]};
                end
            end
        end
        if (edge_take) begin
            mb_cnt_d = mb_cnt_q + 16'd1;
        end
        // Edge storage deliberately keeps stale data on abort.
        if (mb_abort) begin
            cnt_d     = 4'd0;
            idx_err_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 4'd0;
            mb_cnt_q  <= 16'd0;
            idx_err_q <= 1'b0;
            bottom_q  <= 128'd0;
            right_q   <= 128'd0;
        end else begin
            cnt_q     <= cnt_d;
            mb_cnt_q  <= mb_cnt_d;
            idx_err_q <= idx_err_d;
            bottom_q  <= bottom_d;
            right_q   <= right_d;
        end
    end

    assign edge_bottom = bottom_q;
    assign edge_right  = right_q;
    assign mb_cnt      = mb_cnt_q;
    assign idx_err     = idx_err_q;

`ifdef I4_RECON_FULL_MB_EN
    logic [2047:0] pix_q, pix_d;

    // Full-MB store: each accepted block lands its four rows at the cnt position.
    always_comb begin
        pix_d = pix_q;
        if (accept) begin
            for (int p = 0; p < 16; p++) begin
                if (cnt_q == 4'(p)) begin
                    for (int r = 0; r < 4; r++) begin
                        pix_d[128*(4*(p/4) + r) + 32*(p%4) +: 32] = blk_data[32*r +: 32];
                    end
                end
            end
        end
    end

    // Full-MB store register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q <= 2048'd0;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign mb_pix = pix_q;
`endif

endmodule

// File: tb/tb_i4_recon_collector.sv
// Directed bench for i4_recon_collector: inputs driven on the falling edge, outputs checked on the falling edge.
// Expected edges come from a pixel-pattern function of the macroblock picture, independent of the block layout logic.
// Define I4_RECON_FULL_MB_EN to also exercise the full-MB pixel port.
module tb_i4_recon_collector;

    logic           clk;
    logic           rst_n;
    logic           mb_abort;
    logic           blk_valid;
    logic           blk_ready;
    logic [3:0]     blk_idx;
    logic [127:0]   blk_data;
    logic           edge_valid;
    logic           edge_ready;
    logic [127:0]   edge_bottom;
    logic [127:0]   edge_right;
    logic [15:0]    mb_cnt;
    logic           idx_err;
`ifdef I4_RECON_FULL_MB_EN
    logic [2047:0]  mb_pix;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    i4_recon_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mb_abort    (mb_abort),
        .blk_valid   (blk_valid),
        .blk_ready   (blk_ready),
        .blk_idx     (blk_idx),
        .blk_data    (blk_data),
        .edge_valid  (edge_valid),
        .edge_ready  (edge_ready),
        .edge_bottom (edge_bottom),
        .edge_right  (edge_right),
        .mb_cnt      (mb_cnt),
        .idx_err     (idx_err)
`ifdef I4_RECON_FULL_MB_EN
        ,
        .mb_pix      (mb_pix)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Picture pattern: mode 0 = block index*16 + in-block raster pos, mode 1 = 16*Y + X.
    function automatic logic [7:0] pix(input int mode, input int xx, input int yy);
        int i;
        i = (yy / 4) * 4 + xx / 4;
        if (mode == 0) return 8'(i * 16 + (yy % 4) * 4 + (xx % 4));
        else           return 8'(16 * yy + xx);
    endfunction

    function automatic logic [127:0] blk(input int mode, input int i);
        logic [127:0] b;
        b = '0;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                b[32*y + 8*x +: 8] = pix(mode, 4*(i%4) + x, 4*(i/4) + y);
        return b;
    endfunction

    function automatic logic [127:0] exp_bottom(input int mode);
        logic [127:0] e;
        e = '0;
        for (int x = 0; x < 16; x++) e[8*x +: 8] = pix(mode, x, 15);
        return e;
    endfunction

    function automatic logic [127:0] exp_right(input int mode);
        logic [127:0] e;
        e = '0;
        for (int y = 0; y < 16; y++) e[8*y +: 8] = pix(mode, 15, y);
        return e;
    endfunction

    // Sends 16 back-to-back blocks; block at position bad_pos carries blk_idx = bad_idx.
    // Returns on the falling edge after block 15 was accepted.
    task automatic send_mb(input int mode, input int bad_pos, input int bad_idx);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 8)  chk("ready_b2b", 128'(blk_ready), 128'd1);
            if (i == 15) chk("ev_early", 128'(edge_valid), 128'd0);
            blk_valid = 1'b1;
            blk_idx   = (i == bad_pos) ? 4'(bad_idx) : 4'(i);
            blk_data  = blk(mode, i);
        end
        @(negedge clk);
        blk_valid = 1'b0;
        blk_data  = '0;
    endtask

    initial begin
        rst_n      = 1'b0;
        mb_abort   = 1'b0;
        blk_valid  = 1'b0;
        blk_idx    = 4'd0;
        blk_data   = '0;
        edge_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_ready",  128'(blk_ready),  128'd1);
        chk("rst_ev",     128'(edge_valid), 128'd0);
        chk("rst_bottom", edge_bottom,      128'd0);
        chk("rst_right",  edge_right,       128'd0);
        chk("rst_mbcnt",  128'(mb_cnt),     128'd0);
        chk("rst_idxerr", 128'(idx_err),    128'd0);

        // Basic MB with consumer always ready
        edge_ready = 1'b1;
        send_mb(0, -1, 0);
        chk("t1_ev",     128'(edge_valid), 128'd1);
        chk("t1_ready",  128'(blk_ready),  128'd0);
        chk("t1_bottom", edge_bottom,      exp_bottom(0));
        chk("t1_right",  edge_right,       exp_right(0));
        chk("t1_mbcnt0", 128'(mb_cnt),     128'd0);
        @(negedge clk);
        chk("t1_ev_pulse", 128'(edge_valid), 128'd0);
        chk("t1_ready2",   128'(blk_ready),  128'd1);
        chk("t1_mbcnt",    128'(mb_cnt),     128'd1);

        // Consumer stalls 5 cycles
        edge_ready = 1'b0;
        send_mb(1, -1, 0);
        for (int k = 0; k < 5; k++) begin
            chk("t2_ev_hold",  128'(edge_valid), 128'd1);
            chk("t2_rdy_low",  128'(blk_ready),  128'd0);
            chk("t2_bot_hold", edge_bottom,      exp_bottom(1));
            chk("t2_rgt_hold", edge_right,       exp_right(1));
            @(negedge clk);
        end
        chk("t2_ev_c6", 128'(edge_valid), 128'd1);
        edge_ready = 1'b1;
        @(negedge clk);
        chk("t2_ev_done", 128'(edge_valid), 128'd0);
        chk("t2_ready",   128'(blk_ready),  128'd1);
        chk("t2_mbcnt",   128'(mb_cnt),     128'd2);

        // Wrong index at position 7 (claims 3): still stored at 7, idx_err sticky
        chk("t3_err0", 128'(idx_err), 128'd0);
        send_mb(0, 7, 3);
        chk("t3_err1",   128'(idx_err), 128'd1);
        chk("t3_right",  edge_right,    exp_right(0));
        chk("t3_bottom", edge_bottom,   exp_bottom(0));
        @(negedge clk);
        chk("t3_err_hs", 128'(idx_err), 128'd1);
        chk("t3_mbcnt",  128'(mb_cnt),  128'd3);
        mb_abort = 1'b1;
        @(negedge clk);
        mb_abort = 1'b0;
        chk("t3_err_clr", 128'(idx_err), 128'd0);

        // Abort after 9 blocks, with a block offered in the abort cycle
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            blk_valid = 1'b1;
            blk_idx   = 4'(i);
            blk_data  = blk(1, i);
        end
        @(negedge clk);
        blk_idx   = 4'd9;
        blk_data  = blk(1, 9);
        mb_abort  = 1'b1;
        @(negedge clk);
        mb_abort  = 1'b0;
        blk_valid = 1'b0;
        chk("t4_ev",     128'(edge_valid), 128'd0);
        chk("t4_ready",  128'(blk_ready),  128'd1);
        send_mb(0, -1, 0);
        chk("t4_ev1",    128'(edge_valid), 128'd1);
        chk("t4_idxerr", 128'(idx_err),    128'd0);
        chk("t4_bottom", edge_bottom,      exp_bottom(0));
        chk("t4_right",  edge_right,       exp_right(0));
        @(negedge clk);
        chk("t4_mbcnt",  128'(mb_cnt),     128'd4);

        // Abort during FLUSH beats a simultaneous edge handshake
        edge_ready = 1'b0;
        send_mb(1, -1, 0);
        chk("t5_ev1", 128'(edge_valid), 128'd1);
        edge_ready = 1'b1;
        mb_abort   = 1'b1;
        @(negedge clk);
        mb_abort = 1'b0;
        chk("t5_ev0",    128'(edge_valid), 128'd0);
        chk("t5_ready",  128'(blk_ready),  128'd1);
        chk("t5_mbcnt",  128'(mb_cnt),     128'd4);
        chk("t5_bottom", edge_bottom,      exp_bottom(1));

        // mb_cnt wrap
        force dut.mb_cnt_q = 16'hFFFF;
        #1;
        release dut.mb_cnt_q;
        chk("t6_preload", 128'(mb_cnt), 128'hFFFF);
        send_mb(0, -1, 0);
        @(negedge clk);
        chk("t6_wrap", 128'(mb_cnt), 128'd0);

`ifdef I4_RECON_FULL_MB_EN
        // Full-MB store: byte n holds n
        edge_ready = 1'b0;
        send_mb(1, -1, 0);
        for (int y = 0; y < 16; y++) begin
            logic [127:0] e;
            for (int x = 0; x < 16; x++) e[8*x +: 8] = 8'(16*y + x);
            chk($sformatf("t7_row%0d", y), mb_pix[128*y +: 128], e);
        end
        edge_ready = 1'b1;
        @(negedge clk);
        chk("t7_mbcnt", 128'(mb_cnt), 128'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
